// File: rtl/commit_trace_fifo.sv
// Commit-trace FIFO: buffers per-cycle retire records from the core's debug port
// and hands them to the trace checker in order; records that find the buffer full are counted.
module commit_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     debug_commit,
  input  logic [63:0]              debug_pc,
  input  logic [4:0]               debug_rf_wnum,
  input  logic [63:0]              debug_rf_wdata,
  input  logic [7:0]               debug_sram_wen,
  input  logic [31:0]              debug_sram_waddr,
  input  logic [63:0]              debug_sram_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [31:0]              trace_seq,
  output logic [63:0]              trace_pc,
  output logic [4:0]               trace_wnum,
  output logic [63:0]              trace_wdata,
  output logic [7:0]               trace_sram_wen,
  output logic [31:0]              trace_sram_waddr,
  output logic [63:0]              trace_sram_wdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [31:0] seq;
    logic [63:0] pc;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [7:0]  sram_wen;
    logic [31:0] sram_waddr;
    logic [63:0] sram_wdata;
  } rec_t;

  rec_t mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [31:0]      seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;

  logic is_full;
  logic do_pop;
  logic do_push;
  logic do_drop;
  rec_t new_rec;
  rec_t head_rec;

  // Record as stored: x0 writes and absent stores are normalised to zero.
  always_comb begin
    new_rec            = '0;
    new_rec.seq        = seq_q;
    new_rec.pc         = debug_pc;
    new_rec.wnum       = debug_rf_wnum;
    new_rec.wdata      = (debug_rf_wnum == 5'd0) ? 64'd0 : debug_rf_wdata;
    new_rec.sram_wen   = debug_sram_wen;
    new_rec.sram_waddr = (debug_sram_wen == 8'd0) ? 32'd0 : debug_sram_waddr;
    new_rec.sram_wdata = (debug_sram_wen == 8'd0) ? 64'd0 : debug_sram_wdata;
  end

  always_comb begin
    trace_valid  = (level_q != '0);
    is_full      = (level_q == FULL_LEVEL);
    do_pop       = trace_valid && trace_ready;
    // A pop in the same cycle frees the slot, so a full buffer still accepts.
    do_push      = debug_commit && (!is_full || do_pop);
    do_drop      = debug_commit && is_full && !do_pop;

    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    seq_d        = seq_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;

    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Dropped commits still consume a sequence number so the checker sees the gap.
    if (debug_commit) seq_d = seq_q + 32'd1;

    if (do_drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      seq_q        <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      seq_q        <= seq_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && do_push) mem[wr_ptr_q] <= new_rec;
  end

  always_comb begin
    head_rec         = trace_valid ? mem[rd_ptr_q] : '0;
    trace_seq        = head_rec.seq;
    trace_pc         = head_rec.pc;
    trace_wnum       = head_rec.wnum;
    trace_wdata      = head_rec.wdata;
    trace_sram_wen   = head_rec.sram_wen;
    trace_sram_waddr = head_rec.sram_waddr;
    trace_sram_wdata = head_rec.sram_wdata;
    level            = level_q;
    overflow         = overflow_q;
    drop_count       = drop_count_q;
  end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Randomised scoreboard bench for commit_trace_fifo: expected records are queued at
// issue time and a negedge monitor pops and compares them on every handshake.
module tb_commit_trace_fifo;

  localparam int DEPTH = 16;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [31:0] seq;
    logic [63:0] pc;
    logic [4:0]  wnum;
    logic [63:0] wdata;
    logic [7:0]  wen;
    logic [31:0] waddr;
    logic [63:0] sdata;
  } exp_t;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   debug_commit;
  logic [63:0]            debug_pc;
  logic [4:0]             debug_rf_wnum;
  logic [63:0]            debug_rf_wdata;
  logic [7:0]             debug_sram_wen;
  logic [31:0]            debug_sram_waddr;
  logic [63:0]            debug_sram_wdata;
  logic                   trace_valid;
  logic                   trace_ready;
  logic [31:0]            trace_seq;
  logic [63:0]            trace_pc;
  logic [4:0]             trace_wnum;
  logic [63:0]            trace_wdata;
  logic [7:0]             trace_sram_wen;
  logic [31:0]            trace_sram_waddr;
  logic [63:0]            trace_sram_wdata;
  logic [$clog2(DEPTH):0] level;
  logic                   overflow;
  logic [CNT_W-1:0]       drop_count;

  always #5 clock = ~clock;

  commit_trace_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .debug_commit     (debug_commit),
    .debug_pc         (debug_pc),
    .debug_rf_wnum    (debug_rf_wnum),
    .debug_rf_wdata   (debug_rf_wdata),
    .debug_sram_wen   (debug_sram_wen),
    .debug_sram_waddr (debug_sram_waddr),
    .debug_sram_wdata (debug_sram_wdata),
    .trace_valid      (trace_valid),
    .trace_ready      (trace_ready),
    .trace_seq        (trace_seq),
    .trace_pc         (trace_pc),
    .trace_wnum       (trace_wnum),
    .trace_wdata      (trace_wdata),
    .trace_sram_wen   (trace_sram_wen),
    .trace_sram_waddr (trace_sram_waddr),
    .trace_sram_wdata (trace_sram_wdata),
    .level            (level),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  int   model_level = 0;
  int   model_seq   = 0;
  bit   model_ovf   = 1'b0;
  int   model_drops = 0;
  bit   mon_en      = 1'b0;
  bit   hold_valid  = 1'b0;
  exp_t held;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rec(input string name, input exp_t act, input exp_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, update the occupancy-level model, then check state after the edge.
  task automatic drive(input bit rst, input bit commit, input bit rdy,
                       input logic [63:0] pc, input logic [4:0] wn, input logic [63:0] wd,
                       input logic [7:0] wen, input logic [31:0] wa, input logic [63:0] sd);
    exp_t e;
    bit   pop_p;
    bit   full_p;
    reset            = rst;
    debug_commit     = commit;
    trace_ready      = rdy;
    debug_pc         = pc;
    debug_rf_wnum    = wn;
    debug_rf_wdata   = wd;
    debug_sram_wen   = wen;
    debug_sram_waddr = wa;
    debug_sram_wdata = sd;
    if (rst) begin
      sb.delete();
      model_level = 0;
      model_seq   = 0;
      model_ovf   = 1'b0;
      model_drops = 0;
    end else begin
      pop_p  = (model_level > 0) && rdy;
      full_p = (model_level == DEPTH);
      if (commit) begin
        if (!full_p || pop_p) begin
          e.seq   = 32'(model_seq);
          e.pc    = pc;
          e.wnum  = wn;
          e.wdata = (wn == 5'd0) ? 64'd0 : wd;
          e.wen   = wen;
          e.waddr = (wen == 8'd0) ? 32'd0 : wa;
          e.sdata = (wen == 8'd0) ? 64'd0 : sd;
          sb.push_back(e);
          model_level++;
        end else begin
          model_ovf = 1'b1;
          if (model_drops < (1 << CNT_W) - 1) model_drops++;
        end
        model_seq++;
      end
      if (pop_p) model_level--;
    end
    @(posedge clock);
    #1;
    chk("level", 64'(level), 64'(model_level));
    chk("overflow", 64'(overflow), 64'(model_ovf));
    chk("drop_count", 64'(drop_count), 64'(model_drops));
    chk("trace_valid", 64'(trace_valid), 64'(model_level > 0));
  endtask

  task automatic rnd(input bit commit, input bit rdy);
    logic [4:0] wn;
    logic [7:0] wen;
    wn  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    wen = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom);
    drive(1'b0, commit, rdy, {$urandom, $urandom}, wn, {$urandom, $urandom},
          wen, $urandom, {$urandom, $urandom});
  endtask

  task automatic do_reset(input bit commit);
    drive(1'b1, commit, 1'b0, 64'hDEAD_0000, 5'd3, 64'h55, 8'h0F, 32'h40, 64'h66);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) rnd(1'b0, rdy);
  endtask

  // Monitor: every handshake consumes one expected record; idle outputs must be zero.
  always @(negedge clock) begin
    exp_t act;
    exp_t e;
    if (mon_en) begin
      act = {trace_seq, trace_pc, trace_wnum, trace_wdata,
             trace_sram_wen, trace_sram_waddr, trace_sram_wdata};
      if (trace_valid) begin
        if (hold_valid) chk_rec("head_stable", act, held);
        if (trace_ready) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got record %h expected none (t=%0t)", act, $time);
          end else begin
            e = sb.pop_front();
            chk_rec("record", act, e);
          end
          hold_valid = 1'b0;
        end else begin
          held       = act;
          hold_valid = 1'b1;
        end
      end else begin
        chk_rec("idle_zero", act, '0);
        hold_valid = 1'b0;
      end
    end
  end

  initial begin
    do_reset(1'b0);
    mon_en = 1'b1;
    do_reset(1'b0);

    // Single commit then pop.
    drive(1'b0, 1'b1, 1'b1, 64'h8000_0000, 5'd5, 64'h1234, 8'd0, 32'd0, 64'd0);
    idle(2, 1'b1);

    // x0 write and no-store masking.
    drive(1'b0, 1'b1, 1'b0, 64'h8000_0004, 5'd0, 64'hDEAD, 8'd0, 32'h100, 64'h77);
    idle(2, 1'b1);

    // Fill and drop: 20 commits into 16 slots, then drain.
    do_reset(1'b0);
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, 1'b0, 64'h1000 + 64'(i * 4), 5'(i + 1), 64'(i), 8'd1, 32'(i), 64'(i));
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_overflow", 64'(overflow), 64'd1);
    chk("fill_drops", 64'(drop_count), 64'd4);
    idle(17, 1'b1);

    // Full with simultaneous push and pop.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) rnd(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) rnd(1'b1, 1'b1);
    chk("fullpp_level", 64'(level), 64'd16);
    chk("fullpp_drops", 64'(drop_count), 64'd0);
    idle(17, 1'b1);

    // Sequence gap: 18 commits, drain, one more carries seq 18.
    do_reset(1'b0);
    for (int i = 0; i < 18; i++) rnd(1'b1, 1'b0);
    idle(16, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 64'hABC0, 5'd7, 64'h9, 8'd0, 32'd0, 64'd0);
    chk("gap_seq", 64'(trace_seq), 64'd18);
    idle(2, 1'b1);

    // Reset mid-stream with a commit in the reset cycle.
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) rnd(1'b1, 1'b0);
    idle(9, 1'b1);
    chk("mid_level", 64'(level), 64'd7);
    do_reset(1'b1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_valid", 64'(trace_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rnd(1'b1, 1'b0);
    chk("rst_seq0", 64'(trace_seq), 64'd0);
    idle(2, 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(0, 1) == 1);
      else rnd($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1);
    end
    idle(DEPTH + 2, 1'b1);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_fifo.md
# commit_trace_fifo

Buffers per-cycle commit records from the core's debug trace port (commit flag, PC, register-file write, data-SRAM write) and presents them in order to the simulation-side checker over a valid/ready handshake. It sits directly downstream of the CPU top, between the core's `debug_*` outputs and the difftest/trace consumer. The checker may stall; the core cannot. When the buffer is full, records are dropped, counted and flagged, and never silently lost.

## Interface
Parameters:
- `DEPTH`, 16, number of record slots; power of two, ≥ 2.
- `CNT_W`, 16, width of the saturating drop counter.

Ports:
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `debug_commit`  in  1  core retired an instruction this cycle.
- `debug_pc`  in  64  PC of retired instruction.
- `debug_rf_wnum`  in  5  destination register index.
- `debug_rf_wdata`  in  64  destination write data.
- `debug_sram_wen`  in  8  byte-enables of store issued with this commit (0 = no store).
- `debug_sram_waddr`  in  32  store address.
- `debug_sram_wdata`  in  64  store data.
- `trace_valid`  out  1  head record available.
- `trace_ready`  in  1  consumer accepts head record.
- `trace_seq`  out  32  commit sequence number of head record.
- `trace_pc`  out  64  head PC.
- `trace_wnum`  out  5  head register index.
- `trace_wdata`  out  64  head register data.
- `trace_sram_wen`  out  8  head store byte-enables.
- `trace_sram_waddr`  out  32  head store address.
- `trace_sram_wdata`  out  64  head store data.
- `level`  out  $clog2(DEPTH)+1  records currently held.
- `overflow`  out  1  sticky; set on the first dropped record.
- `drop_count`  out  CNT_W  dropped records, saturating at all-ones.

## Operation
- Push: `debug_commit`=1 in a cycle. The record {seq, pc, wnum, wdata', sram_wen, sram_waddr, sram_wdata} is written at the write pointer.
- `wdata'` is `debug_rf_wdata`, except it is forced to 0 when `debug_rf_wnum`=0 (x0 is never written).
- When `debug_sram_wen`=0, the stored `sram_waddr` and `sram_wdata` are forced to 0.
- Sequence counter: 32-bit and wrapping. It increments on every `debug_commit`, whether the record is accepted or dropped, so the consumer sees gaps in `trace_seq` at each drop. The first commit after reset carries seq 0.
- Pop: `trace_valid && trace_ready` in a cycle. The read pointer advances.
- Full, no pop, push: the record is discarded. `overflow` is set to 1 and `drop_count` is incremented, saturating. The sequence counter still increments.
- Full with simultaneous pop and push: both occur and the record is accepted. `level` stays at DEPTH.
- Empty with push: no bypass. The record appears the next cycle.
- `trace_ready` while `trace_valid`=0 has no effect.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. Full/empty is derived from `level`.
- All `trace_*` data outputs are driven 0 whenever `trace_valid`=0.
- `overflow` clears only on `reset`.

## Timing
- Reset (synchronous): on the next edge with `reset`=1, the following are all 0:
  - pointers, `level`, sequence counter;
  - `overflow`, `drop_count`;
  - `trace_valid` and all `trace_*` outputs.
- Reset mid-operation discards every buffered record. A `debug_commit` in the reset cycle is ignored and does not consume a sequence number.
- Latency: a commit sampled at edge N gives `trace_valid`=1 with that record after edge N, i.e. visible in cycle N+1.
- Head outputs are read combinationally from storage at the read pointer. They stay stable while `trace_valid`=1 and `trace_ready`=0.
- Throughput: one push and one pop per cycle, sustained.
- `level` updates per edge:
  - +1 on a push without a pop;
  - −1 on a pop without a push;
  - unchanged on both, or on neither.

## Test plan
- Single commit, reset then push pc=0x80000000, wnum=5, wdata=0x1234, consumer ready → next cycle: `trace_valid`=1, seq=0, pc=0x80000000, wdata=0x1234; after the pop, `level`=0.
- x0 and no-store masking, push wnum=0, wdata=0xDEAD, sram_wen=0, waddr=0x100 → record has wdata=0 and waddr=0.
- Fill and drop, DEPTH=16, `trace_ready`=0, 20 consecutive commits:
  - `level`=16, `overflow`=1, `drop_count`=4;
  - draining yields seq 0..15 in order, pc matching the pushes.
- Full with simultaneous push/pop: at `level`=16, hold `trace_ready`=1 and `debug_commit`=1 for 8 cycles → no drops, `level` stays 16, output seq increments by 1 per cycle.
- Sequence gap after drop: overflow by 2, then drain and push one more → that last record carries seq 18 following 15 (for 18 commits into DEPTH=16).
- Reset mid-stream: at `level`=7 with `overflow`=1, assert `reset` for one cycle alongside `debug_commit` → `level`=0, `trace_valid`=0, `overflow`=0; the next commit carries seq 0.
